cadence_meas: RTL

- Converts the raw crank cadence-sensor pulse train into the filtered 5-bit `cadence` value and the `not_pedaling` flag.
- Both outputs feed the desired-drive math stage directly.
- Processing chain: synchronize, debounce, count rising edges per fixed window, then exponentially filter.
- Sits between the sensor pin and the desired-drive calculation.

---
 rtl/cadence_meas.sv | 116 +++++++++++
 1 files changed

// File: rtl/cadence_meas.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : cadence_meas                                                     |
// | Brief   : Crank cadence sensor -> synchronized, debounced, windowed edge   |
// |           count, exponentially filtered into a 5-bit cadence value.        |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module cadence_meas #(
  parameter int WIN_W   = 24,
  parameter int DEB_CNT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cadence_raw,
  output logic [4:0] cadence,
  output logic       not_pedaling,
  output logic       cadence_vld
);

  localparam int                  c_dcnt_w   = $clog2(DEB_CNT);
  localparam logic [c_dcnt_w-1:0] c_dcnt_max = c_dcnt_w'(DEB_CNT - 1);

  logic                r_sync1;
  logic                r_sync2;
  logic                r_deb;
  logic                r_deb_q;
  logic [c_dcnt_w-1:0] r_dcnt;
  logic [WIN_W-1:0]    r_win;
  logic [5:0]          r_ecnt;
  logic [6:0]          r_acc;

  logic                w_rise;
  logic                w_term;
  logic [4:0]          w_smp;
  logic [6:0]          w_acc_next;

  // Two-flop synchronizer for the asynchronous sensor pin
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= cadence_raw;
      r_sync2 <= r_sync1;
    end
  end

  // The debounced level follows only after DEB_CNT consecutive differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      r_deb   <= 1'b0;
      r_deb_q <= 1'b0;
      r_dcnt  <= '0;
    end else begin
      r_deb_q <= r_deb;
      if (r_sync2 == r_deb) begin
        r_dcnt <= '0;
      end else if (r_dcnt == c_dcnt_max) begin
        r_deb  <= r_sync2;
        r_dcnt <= '0;
      end else begin
        r_dcnt <= r_dcnt + 1'b1;
      end
    end
  end

  assign w_rise = r_deb & ~r_deb_q;
  assign w_term = &r_win;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_win <= '0;
    end else begin
      r_win <= r_win + 1'b1;
    end
  end

  // Edge counter; a rise on the terminal cycle opens the next window's count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ecnt <= '0;
    end else if (w_term) begin
      r_ecnt <= {5'd0, w_rise};
    end else if (w_rise && (r_ecnt != 6'd63)) begin
      r_ecnt <= r_ecnt + 6'd1;
    end
  end

  assign w_smp = (r_ecnt > 6'd31) ? 5'd31 : r_ecnt[4:0];

  // acc - acc/4 is at most 93 and smp at most 31, so 7 bits never overflow
  always_comb begin
    w_acc_next = '0;
    if (w_smp != 5'd0) begin
      w_acc_next = r_acc - {2'b00, r_acc[6:2]} + {2'b00, w_smp};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc        <= '0;
      cadence      <= '0;
      not_pedaling <= 1'b1;
      cadence_vld  <= 1'b0;
    end else begin
      cadence_vld <= w_term;
      if (w_term) begin
        r_acc        <= w_acc_next;
        cadence      <= w_acc_next[6:2];
        not_pedaling <= (w_smp == 5'd0) | (w_acc_next < 7'd8);
      end
    end
  end

endmodule
`default_nettype wire
